// File: rtl/jt51_interpol_pkg.sv
// Shared types and helpers for the stereo polyphase interpolator.
package jt51_interpol_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MACL = 3'd2,
        ST_MACR = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Coefficient count at default parameters (phases * taps)
    localparam int DEF_NCOEFF = 32;

    // Clamp a signed value into the range of an ow-bit signed number
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/jt51_interpol_ram.sv
// History buffer: small synchronous RAM, 1-cycle read latency, cleared on reset.
module jt51_interpol_ram #(
    parameter int dw = 16,
    parameter int aw = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [aw-1:0] addr_i,
    input  logic [dw-1:0] wdata_i,
    output logic [dw-1:0] rdata_o
);

    logic [dw-1:0] mem_q [2**aw];
    logic [dw-1:0] rdata_q;

    // Write on we_i, always read the addressed word (read-before-write)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**aw; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jt51_interpol.sv
// Stereo polyphase 1:L interpolating FIR, one shared multiplier alternating L/R.
// MAC pipeline: A = history read + coefficient index, B = multiply, C = accumulate.
module jt51_interpol
    import jt51_interpol_pkg::*;
#(
    parameter int data_width   = 16,
    parameter int output_width = 16,
    parameter int coeff_width  = 16,
    parameter int phases       = 4,
    parameter int taps         = 8,
    parameter int hist_width   = 3,
    parameter int caddr_width  = 5,
    parameter int gain_shift   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample,
    input  logic signed [data_width-1:0]  left_in,
    input  logic signed [data_width-1:0]  right_in,
    input  logic                          tick,
    input  logic signed [coeff_width-1:0] coeff,
    output logic [caddr_width-1:0]        coeff_addr,
    output logic signed [output_width-1:0] left_out,
    output logic signed [output_width-1:0] right_out,
    output logic                          sample_out,
    output logic                          overrun,
    output logic                          underrun
);

    localparam int PW  = data_width + coeff_width;
    localparam int AW  = PW + hist_width;
    localparam int SH  = coeff_width - 1 - gain_shift;
    localparam int PHW = $clog2(phases) + 1;

    state_t                         state_q;
    logic                           last_sample_q, last_tick_q;
    logic                           samp_edge, tick_edge;
    logic [hist_width-1:0]          wptr_q, k_q, kd_q;
    logic [PHW-1:0]                 p_q, pl_q;
    logic                           pend_q, tpend_q;
    logic signed [data_width-1:0]   pend_l_q, pend_r_q;
    logic                           chan_a_q, chan_b_q;
    logic [1:0]                     vld_pipe_q;
    logic signed [PW-1:0]           prod_q, mult;
    logic signed [AW-1:0]           acc_l_q, acc_r_q;
    logic signed [output_width-1:0] left_q, right_q;
    logic                           sample_out_q, overrun_q, underrun_q;
    logic                           ram_we, mac_issue;
    logic [hist_width-1:0]          ram_addr;
    logic signed [data_width-1:0]   rd_l, rd_r, mop;

    assign samp_edge = sample & ~last_sample_q;
    assign tick_edge = tick & ~last_tick_q;
    assign mac_issue = (state_q == ST_MACL) || (state_q == ST_MACR);

    // LOAD writes the new newest slot; otherwise read x[n-k] at wptr+k
    assign ram_we   = (state_q == ST_LOAD);
    assign ram_addr = ram_we ? wptr_q - hist_width'(1) : wptr_q + k_q;

    jt51_interpol_ram #(.dw(data_width), .aw(hist_width)) u_ram_l (
        .clk(clk), .rst_n(rst_n), .we_i(ram_we), .addr_i(ram_addr),
        .wdata_i(pend_l_q), .rdata_o(rd_l)
    );

    jt51_interpol_ram #(.dw(data_width), .aw(hist_width)) u_ram_r (
        .clk(clk), .rst_n(rst_n), .we_i(ram_we), .addr_i(ram_addr),
        .wdata_i(pend_r_q), .rdata_o(rd_r)
    );

    // Coefficient index follows stage B (tap of the word just read)
    assign coeff_addr = caddr_width'(kd_q) * caddr_width'(phases) + caddr_width'(pl_q);
    assign mop        = chan_a_q ? rd_r : rd_l;
    assign mult       = PW'(mop) * PW'(coeff);

    function automatic logic signed [output_width-1:0] to_out(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> SH;
        return output_width'(sat_s({{(64-AW){s[AW-1]}}, s}, output_width));
    endfunction

    // Strobe edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sample_q <= 1'b0;
            last_tick_q   <= 1'b0;
        end else begin
            last_sample_q <= sample;
            last_tick_q   <= tick;
        end
    end

    // Control FSM: sample/tick arbitration, phase tracking, output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            k_q          <= '0;
            p_q          <= '0;
            pl_q         <= '0;
            pend_q       <= 1'b0;
            tpend_q      <= 1'b0;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            left_q       <= '0;
            right_q      <= '0;
            sample_out_q <= 1'b0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            sample_out_q <= 1'b0;
            // Data is captured at the edge; a second edge while pending replaces it
            if (samp_edge) begin
                pend_l_q <= left_in;
                pend_r_q <= right_in;
                if (pend_q) overrun_q <= 1'b1;
            end
            if (state_q != ST_IDLE) begin
                if (samp_edge) pend_q <= 1'b1;
                if (tick_edge) overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pend_q || samp_edge) begin
                        state_q <= ST_LOAD;
                        pend_q  <= 1'b0;
                        if (tick_edge) tpend_q <= 1'b1;
                    end else if (tick_edge || tpend_q) begin
                        state_q <= ST_MACL;
                        tpend_q <= 1'b0;
                        k_q     <= '0;
                        if (tick_edge && tpend_q) overrun_q <= 1'b1;
                        // Ran out of phases: repeat the last one
                        if (p_q == PHW'(phases)) begin
                            pl_q       <= PHW'(phases - 1);
                            underrun_q <= 1'b1;
                        end else begin
                            pl_q <= p_q;
                        end
                    end
                end
                ST_LOAD: begin
                    wptr_q  <= wptr_q - hist_width'(1);
                    p_q     <= '0;
                    state_q <= ST_IDLE;
                end
                ST_MACL: state_q <= ST_MACR;
                ST_MACR: begin
                    k_q     <= k_q + hist_width'(1);
                    state_q <= (k_q == hist_width'(taps - 1)) ? ST_DONE : ST_MACL;
                end
                ST_DONE: begin
                    // Wait for the multiply/accumulate pipeline to drain
                    if (vld_pipe_q == 2'b00) begin
                        left_q       <= to_out(acc_l_q);
                        right_q      <= to_out(acc_r_q);
                        sample_out_q <= 1'b1;
                        if (p_q != PHW'(phases)) p_q <= p_q + PHW'(1);
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // MAC datapath: shared multiplier, per-channel accumulators cleared while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            chan_a_q   <= 1'b0;
            chan_b_q   <= 1'b0;
            kd_q       <= '0;
            prod_q     <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], mac_issue};
            chan_a_q   <= (state_q == ST_MACR);
            kd_q       <= k_q;
            chan_b_q   <= chan_a_q;
            prod_q     <= mult;
            if (state_q == ST_IDLE) begin
                acc_l_q <= '0;
                acc_r_q <= '0;
            end else if (vld_pipe_q[1]) begin
                if (chan_b_q) acc_r_q <= acc_r_q + {{hist_width{prod_q[PW-1]}}, prod_q};
                else          acc_l_q <= acc_l_q + {{hist_width{prod_q[PW-1]}}, prod_q};
            end
        end
    end

    assign left_out   = left_q;
    assign right_out  = right_q;
    assign sample_out = sample_out_q;
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_jt51_interpol.sv
// Self-checking bench for jt51_interpol against a direct-form polyphase model.
module tb_jt51_interpol;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sample, tick;
    logic signed [15:0] left_in, right_in;
    logic signed [15:0] coeff;
    logic [4:0]         coeff_addr;
    logic signed [15:0] left_out, right_out;
    logic               sample_out, overrun, underrun;

    logic signed [15:0] rom [32];
    int  hl [8];
    int  hr [8];
    int  mp;
    bit  exp_under;
    int  checks, errors;

    always #5 clk = ~clk;
    assign coeff = rom[coeff_addr];

    jt51_interpol dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .left_in(left_in), .right_in(right_in),
        .tick(tick), .coeff(coeff), .coeff_addr(coeff_addr), .left_out(left_out),
        .right_out(right_out), .sample_out(sample_out), .overrun(overrun), .underrun(underrun)
    );

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin hl[i] = 0; hr[i] = 0; end
        mp = 0;
        exp_under = 0;
    endtask

    task automatic model_sample(input int l, input int r);
        for (int i = 7; i > 0; i--) begin hl[i] = hl[i-1]; hr[i] = hr[i-1]; end
        hl[0] = l;
        hr[0] = r;
        mp = 0;
    endtask

    function automatic logic signed [15:0] ref_out(input bit right, input int ph);
        longint acc = 0;
        longint v;
        for (int k = 0; k < 8; k++)
            acc += longint'(right ? hr[k] : hl[k]) * longint'(rom[k*4 + ph]);
        v = acc >>> 13;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    task automatic model_tick(output logic signed [15:0] el, output logic signed [15:0] er);
        int ph;
        if (mp >= 4) begin ph = 3; exp_under = 1; end
        else begin ph = mp; mp++; end
        el = ref_out(1'b0, ph);
        er = ref_out(1'b1, ph);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_sample(input int l, input int r);
        @(posedge clk); #1;
        sample = 1'b1; left_in = 16'(l); right_in = 16'(r);
        @(posedge clk); #1;
        sample = 1'b0;
        repeat (3) @(posedge clk);
        model_sample(l, r);
    endtask

    task automatic run_tick(output logic signed [15:0] l, output logic signed [15:0] r,
                            output int lat, output bit to);
        @(posedge clk); #1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); lat++; #1;
        end while (!sample_out && lat < 60);
        to = !sample_out;
        l = left_out;
        r = right_out;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (left_out !== 16'sd0 || right_out !== 16'sd0) begin
            errors++; $display("FAIL reset_data: got %0d/%0d want 0/0", left_out, right_out);
        end
        checks++;
        if ({sample_out, overrun, underrun} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {sample_out, overrun, underrun});
        end
        checks++;
        if (coeff_addr !== 5'd0) begin
            errors++; $display("FAIL reset_caddr: got %0d want 0", coeff_addr);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_impulse(input string tag);
        logic signed [15:0] l, r, el, er;
        int lat; bit to;
        for (int i = 0; i < 32; i++) rom[i] = 16'(i + 1);
        for (int s = 0; s < 9; s++) begin
            send_sample(s == 0 ? 8192 : 0, 0);
            for (int t = 0; t < 4; t++) begin
                model_tick(el, er);
                run_tick(l, r, lat, to);
                checks++;
                if (to) begin errors++; $display("FAIL %s_timeout: no sample_out s=%0d t=%0d", tag, s, t); end
                checks++;
                if (l !== 16'(s < 8 ? 4*s + t + 1 : 0)) begin
                    errors++; $display("FAIL %s_left s=%0d t=%0d: got %0d want %0d", tag, s, t, l, s < 8 ? 4*s + t + 1 : 0);
                end
                checks++;
                if (r !== 16'sd0) begin errors++; $display("FAIL %s_right s=%0d t=%0d: got %0d want 0", tag, s, t, r); end
            end
        end
    endtask

    task automatic test_dc();
        logic signed [15:0] l, r, el, er;
        int lat; bit to;
        for (int i = 0; i < 32; i++) rom[i] = 16'sd1024;
        for (int s = 0; s < 10; s++) begin
            send_sample(8192, 8192);
            for (int t = 0; t < 4; t++) begin
                model_tick(el, er);
                run_tick(l, r, lat, to);
                checks++;
                if (to || l !== el || r !== er) begin
                    errors++; $display("FAIL dc_model s=%0d t=%0d: got %0d/%0d want %0d/%0d", s, t, l, r, el, er);
                end
                if (s >= 7) begin
                    checks++;
                    if (l !== 16'sd8192 || r !== 16'sd8192) begin
                        errors++; $display("FAIL dc_gain s=%0d t=%0d: got %0d/%0d want 8192", s, t, l, r);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] l, r, el, er;
        int lat; bit to;
        int v;
        for (int i = 0; i < 32; i++) rom[i] = 16'sd32767;
        for (int s = 0; s < 16; s++) begin
            v = (s < 8) ? 32767 : -32768;
            send_sample(v, v);
            for (int t = 0; t < 4; t++) begin
                model_tick(el, er);
                run_tick(l, r, lat, to);
                checks++;
                if (to || l !== el || r !== er) begin
                    errors++; $display("FAIL sat_model s=%0d t=%0d: got %0d/%0d want %0d/%0d", s, t, l, r, el, er);
                end
                if (s == 7 || s == 15) begin
                    checks++;
                    if (l !== 16'(v) || r !== 16'(v)) begin
                        errors++; $display("FAIL sat_clip s=%0d t=%0d: got %0d/%0d want %0d", s, t, l, r, v);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic signed [15:0] l, r, el, er;
        int lat; bit to;
        int nt;
        for (int i = 0; i < 32; i++) rom[i] = 16'($urandom_range(0, 65535));
        for (int s = 0; s < 24; s++) begin
            send_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
            nt = int'($urandom_range(1, 4));
            for (int t = 0; t < nt; t++) begin
                model_tick(el, er);
                run_tick(l, r, lat, to);
                checks++;
                if (to || l !== el || r !== er) begin
                    errors++; $display("FAIL rand s=%0d t=%0d: got %0d/%0d want %0d/%0d", s, t, l, r, el, er);
                end
            end
        end
        checks++;
        if (overrun !== 1'b0 || underrun !== 1'b0) begin
            errors++; $display("FAIL rand_flags: got ov=%b un=%b want 0/0", overrun, underrun);
        end
    endtask

    task automatic test_underrun();
        logic signed [15:0] l, r, el, er, l4;
        int lat; bit to;
        l4 = '0;
        send_sample(int'($urandom_range(1000, 20000)), int'($urandom_range(1000, 20000)));
        for (int t = 0; t < 6; t++) begin
            model_tick(el, er);
            run_tick(l, r, lat, to);
            checks++;
            if (to || l !== el || r !== er) begin
                errors++; $display("FAIL under_model t=%0d: got %0d/%0d want %0d/%0d", t, l, r, el, er);
            end
            if (t == 3) l4 = l;
            if (t >= 4) begin
                checks++;
                if (l !== l4) begin errors++; $display("FAIL under_repeat t=%0d: got %0d want %0d", t, l, l4); end
            end
            checks++;
            if (underrun !== exp_under) begin
                errors++; $display("FAIL under_flag t=%0d: got %b want %b", t, underrun, exp_under);
            end
        end
        send_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        model_tick(el, er);
        run_tick(l, r, lat, to);
        checks++;
        if (to || l !== el || r !== er) begin
            errors++; $display("FAIL under_restart: got %0d/%0d want %0d/%0d", l, r, el, er);
        end
    endtask

    task automatic test_timing_overrun();
        logic signed [15:0] el, er, l, r;
        int first, pulses, lat; bit to;
        int nl, nr;
        send_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b want 0", overrun); end
        // tick, then a second tick 5 cycles later that must be dropped
        model_tick(el, er);
        @(posedge clk); #1; tick = 1'b1;
        @(posedge clk); #1; tick = 1'b0;
        first = 0; pulses = 0; l = '0; r = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 4) tick = 1'b1;
            if (cyc == 5) tick = 1'b0;
            if (sample_out) begin
                pulses++;
                if (first == 0) begin first = cyc; l = left_out; r = right_out; end
            end
        end
        checks++;
        if (first != 19) begin errors++; $display("FAIL latency: got %0d want 19", first); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", pulses); end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        checks++;
        if (l !== el || r !== er) begin errors++; $display("FAIL ovr_data: got %0d/%0d want %0d/%0d", l, r, el, er); end
        // sample edge mid-MAC: current result uses old history, new sample loads after DONE
        nl = int'($urandom_range(0, 65535)) - 32768;
        nr = int'($urandom_range(0, 65535)) - 32768;
        model_tick(el, er);
        @(posedge clk); #1; tick = 1'b1;
        @(posedge clk); #1; tick = 1'b0;
        first = 0; pulses = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 5) begin sample = 1'b1; left_in = 16'(nl); right_in = 16'(nr); end
            if (cyc == 6) sample = 1'b0;
            if (sample_out) begin
                pulses++;
                if (first == 0) begin first = cyc; l = left_out; r = right_out; end
            end
        end
        checks++;
        if (first != 19 || pulses != 1) begin
            errors++; $display("FAIL midmac_timing: got first=%0d pulses=%0d want 19/1", first, pulses);
        end
        checks++;
        if (l !== el || r !== er) begin errors++; $display("FAIL midmac_old: got %0d/%0d want %0d/%0d", l, r, el, er); end
        model_sample(nl, nr);
        model_tick(el, er);
        run_tick(l, r, lat, to);
        checks++;
        if (to || l !== el || r !== er) begin
            errors++; $display("FAIL midmac_new: got %0d/%0d want %0d/%0d", l, r, el, er);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(posedge clk); #1; tick = 1'b1;
        @(posedge clk); #1; tick = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (left_out !== 16'sd0 || right_out !== 16'sd0 || {sample_out, overrun, underrun} !== 3'b000) begin
            errors++; $display("FAIL rstmid_state: got %0d/%0d flags %b want 0/0 000",
                               left_out, right_out, {sample_out, overrun, underrun});
        end
        rst_n = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (sample_out) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rstmid_pulse: got %0d want 0", pulses); end
        model_clear();
        test_impulse("reimp");
    endtask

    initial begin
        checks = 0; errors = 0;
        sample = 1'b0; tick = 1'b0; left_in = '0; right_in = '0;
        for (int i = 0; i < 32; i++) rom[i] = 16'(i + 1);
        model_clear();
        test_reset();
        test_impulse("imp");
        test_dc();
        test_saturation();
        test_random();
        test_underrun();
        test_timing_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
